fifo_rr_read_arbiter: RTL and testbench

FIFO_RR_READ_ARBITER -- requirements
Module: fifo_rr_read_arbiter

---
 rtl/fifo_rr_read_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_rr_read_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin read arbiter over four first-word-fall-through FIFOs.
// Each FIFO carries packets: a header word whose low LEN_SZ bits give the
// number of payload words that follow. A granted FIFO is drained for one
// whole packet before arbitration happens again, so packets never interleave.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A word
// moves when out_valid & out_ready are both high on a rising clk edge.
// out_valid never depends on out_ready. While out_valid is high and
// out_ready is low, out_data/out_sop/out_eop hold. rinc[grant] is the same
// transfer term, so the FIFO pops exactly the word that downstream took.
module fifo_rr_read_arbiter #(
  parameter int DATA_SZ = 8,
  parameter int LEN_SZ  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           rempty,
  input  logic [4*DATA_SZ-1:0] rdata,
  output logic [3:0]           rinc,
  output logic [DATA_SZ-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          last_grant;
  logic [LEN_SZ-1:0]   remaining;

  logic [DATA_SZ-1:0]  head_word;
  logic                active;
  logic                last_word;
  logic                xfer;
  logic                any_req;
  logic [1:0]          rr_pick;

  // Datapath: present the granted FIFO head and derive the handshake terms.
  always_comb begin
    head_word = rdata[int'(grant)*DATA_SZ +: DATA_SZ];
    active    = (state != IDLE);
    out_valid = active & ~rempty[grant];
    out_data  = active ? head_word : '0;
    // A header with zero length is also the last word of its packet.
    if (state == HEADER) begin
      last_word = (head_word[LEN_SZ-1:0] == '0);
    end else begin
      last_word = (remaining == LEN_SZ'(1));
    end
    out_sop   = out_valid & (state == HEADER);
    out_eop   = out_valid & last_word;
    xfer      = out_valid & out_ready;
    rinc      = xfer ? (4'b0001 << grant) : 4'b0000;
    busy      = active;
  end

  // Round-robin pick: first non-empty FIFO starting at last_grant+1.
  // Scanning from the farthest candidate to the nearest lets the nearest win.
  always_comb begin
    logic [1:0] idx;
    any_req = ~&rempty;
    rr_pick = last_grant;
    idx     = last_grant;
    for (int k = 3; k >= 0; k--) begin
      idx = last_grant + 2'(k + 1);
      if (!rempty[idx]) begin
        rr_pick = idx;
      end
    end
  end

  // Packet FSM: arbitrate in IDLE, then walk header and payload of one packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      remaining  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= rr_pick;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) begin
            remaining <= head_word[LEN_SZ-1:0];
            if (last_word) begin
              state      <= IDLE;
              last_grant <= grant;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            remaining <= remaining - LEN_SZ'(1);
            if (last_word) begin
              state      <= IDLE;
              last_grant <= grant;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Bench for fifo_rr_read_arbiter: four queue-backed FWFT FIFO models, an
// expected-word scoreboard, hand-written corner sequences and a table of
// round-robin arbitration vectors.
module tb_fifo_rr_read_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  rinc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  fifo_rr_read_arbiter #(.DATA_SZ(8), .LEN_SZ(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .grant     (grant),
    .busy      (busy)
  );

  // ---------------- FIFO models and scoreboard ----------------
  logic [7:0]  fq [4][$];
  logic [3:0]  mask;        // forces a FIFO to look empty
  logic [3:0]  pend;        // pops the DUT requested in the current cycle
  logic        ready_next;  // out_ready value applied after the next edge
  logic [11:0] exp_q [$];   // {grant, sop, eop, data}
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [1:0] prior;
    logic [3:0] req;
    logic [2:0] n;
    logic [7:0] order;  // {o3, o2, o1, o0}
  } vec_t;

  vec_t vecs [5];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endfunction

  function automatic logic [7:0] val(int v, int i);
    return {3'(v), 2'(i), 3'b000};
  endfunction

  task automatic push_exp(logic [1:0] g, logic sop, logic eop, logic [7:0] d);
    exp_q.push_back({g, sop, eop, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      rempty[i] = (fq[i].size() == 0) || mask[i];
      rdata[i*8 +: 8] = (fq[i].size() != 0) ? fq[i][0] : 8'($urandom_range(0, 255));
    end
    out_ready = ready_next;
  endtask

  task automatic observe();
    logic        xfer;
    logic [3:0]  er;
    logic [11:0] e;
    xfer = out_valid & out_ready;
    er   = 4'b0000;
    if (xfer && exp_q.size() != 0) er = 4'b0001 << exp_q[0][11:10];
    chk("rinc", rinc, er);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h from fifo %0d, expected none", out_data, grant);
      end else begin
        e = exp_q.pop_front();
        chk("word{grant,sop,eop,data}", {grant, out_sop, out_eop, out_data}, e);
      end
    end
    pend = xfer ? rinc : 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    pend = 4'b0000;
    refresh();
    #1;
    observe();
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words outstanding after %0d cycles, expected 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rinc"}, rinc, 4'b0000);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_sop"}, out_sop, 1'b0);
    chk({tag, "_eop"}, out_eop, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_data"}, out_data, 8'h00);
    chk({tag, "_grant"}, grant, 2'd0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    pend       = 4'b0000;
    mask       = 4'b0000;
    ready_next = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) fq[i].delete();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    refresh();
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Round-robin table: prior grant, requesting FIFOs, expected grant order.
    vecs[0] = '{prior: 2'd1, req: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[1] = '{prior: 2'd0, req: 4'b1111, n: 3'd4, order: {2'd0, 2'd3, 2'd2, 2'd1}};
    vecs[2] = '{prior: 2'd2, req: 4'b0101, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[3] = '{prior: 2'd3, req: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[4] = '{prior: 2'd1, req: 4'b0110, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd2}};

    // A: one packet of length 3 from FIFO2 straight after reset.
    do_reset();
    fq[2] = '{8'h03, 8'ha1, 8'hb2, 8'hc3};
    push_exp(2'd2, 1'b1, 1'b0, 8'h03);
    push_exp(2'd2, 1'b0, 1'b0, 8'ha1);
    push_exp(2'd2, 1'b0, 1'b0, 8'hb2);
    push_exp(2'd2, 1'b0, 1'b1, 8'hc3);
    refresh();
    #1;
    chk("a_idle_valid", out_valid, 1'b0);
    chk("a_idle_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a_valid", out_valid, 1'b1);
    end
    tick();
    chk("a_busy_after", busy, 1'b0);
    chk("a_words_left", exp_q.size(), 0);

    // B: header-only packet in every FIFO, served 0..3 with idle gaps.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fq[i].push_back(val(1, i));
      push_exp(2'(i), 1'b1, 1'b1, val(1, i));
    end
    refresh();
    #1;
    chk("b_idle_valid", out_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b_valid_pattern", out_valid, (k % 2) == 0);
    end
    tick();
    chk("b_busy_after", busy, 1'b0);
    chk("b_words_left", exp_q.size(), 0);

    // C: granted FIFO runs dry mid-packet while FIFO3 waits.
    do_reset();
    fq[1] = '{8'h02, 8'h11, 8'h22};
    fq[3] = '{8'h08};
    push_exp(2'd1, 1'b1, 1'b0, 8'h02);
    push_exp(2'd1, 1'b0, 1'b0, 8'h11);
    push_exp(2'd1, 1'b0, 1'b1, 8'h22);
    push_exp(2'd3, 1'b1, 1'b1, 8'h08);
    refresh();
    #1;
    tick();
    chk("c_grant_hdr", grant, 2'd1);
    tick();
    mask = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("c_stall_valid", out_valid, 1'b0);
      chk("c_stall_grant", grant, 2'd1);
      chk("c_stall_busy", busy, 1'b1);
    end
    mask = 4'b0000;
    tick();
    chk("c_last_eop", out_eop, 1'b1);
    drain(20);

    // D: downstream stalls the header for five cycles.
    do_reset();
    ready_next = 1'b0;
    fq[0] = '{8'h01, 8'h5a};
    push_exp(2'd0, 1'b1, 1'b0, 8'h01);
    push_exp(2'd0, 1'b0, 1'b1, 8'h5a);
    refresh();
    #1;
    chk("d_idle_valid", out_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("d_hold_valid", out_valid, 1'b1);
      chk("d_hold_data", out_data, 8'h01);
      chk("d_hold_sop", out_sop, 1'b1);
    end
    ready_next = 1'b1;
    tick();
    chk("d_words_left", exp_q.size(), 1);
    drain(20);

    // E: reset pulled in the middle of a FIFO0 payload.
    do_reset();
    fq[0] = '{8'h03, 8'h01, 8'h55, 8'h00};
    push_exp(2'd0, 1'b1, 1'b0, 8'h03);
    push_exp(2'd0, 1'b0, 1'b0, 8'h01);
    refresh();
    #1;
    tick();
    tick();
    rst  = 1'b0;
    pend = 4'b0000;
    #1;
    check_reset_outputs("e_async");
    fq[1].push_back(8'h40);
    push_exp(2'd0, 1'b1, 1'b0, 8'h01);
    push_exp(2'd0, 1'b0, 1'b1, 8'h55);
    push_exp(2'd1, 1'b1, 1'b1, 8'h40);
    push_exp(2'd0, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    refresh();
    #1;
    chk("e_release_valid", out_valid, 1'b0);
    tick();
    chk("e_first_grant", grant, 2'd0);
    drain(40);

    // F: round-robin table.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      fq[vecs[v].prior].push_back(8'hf8);
      push_exp(vecs[v].prior, 1'b1, 1'b1, 8'hf8);
      refresh();
      #1;
      drain(20);
      for (int i = 0; i < 4; i++) begin
        if (vecs[v].req[i]) fq[i].push_back(val(v, i));
      end
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        push_exp(vecs[v].order[2*k +: 2], 1'b1, 1'b1, val(v, int'(vecs[v].order[2*k +: 2])));
      end
      refresh();
      #1;
      tick();
      chk("f_first_grant", grant, vecs[v].order[1:0]);
      drain(40);
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
